// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, wait
// counter width and the word-index width helper.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int CNT_W = 4;

  // Number of address bits needed to index a word array of the given depth.
  function automatic int word_idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word array with synchronous write and a registered, enable-gated read port.
// Only the read register is reset; the storage itself is not.
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int DATA_W = 32,
  localparam int IDX_W = word_idx_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              re,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_r [DEPTH];

  // Storage write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[idx] <= wdata;
    end
  end

  // Read register holds the last loaded word until the next read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= {DATA_W{1'b0}};
    end else if (re) begin
      rdata <= mem_r[idx];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts MemRead/MemWrite from the control decoder,
// stalls the pipeline for WAIT_CYCLES+1 cycles and completes in a DONE cycle.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              stall,
  output logic              done,
  output logic              misalign,
  output logic              range_err
);

  localparam int             IDX_W     = word_idx_w(DEPTH);
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic           NO_WAIT   = (WAIT_CYCLES == 0);

  state_t            state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [IDX_W-1:0]  idx_r;
  logic [DATA_W-1:0] wdata_r;
  logic              is_write_r;
  logic              done_r;
  logic              misalign_r;
  logic              range_err_r;

  logic              idle_s;
  logic              req_s;
  logic              misaligned_s;
  logic              oob_s;
  logic              both_s;
  logic              accept_s;
  logic              commit_s;
  logic              acc_write_s;
  logic [IDX_W-1:0]  acc_idx_s;
  logic [DATA_W-1:0] acc_wdata_s;

  // Request decode, stall and commit strobes for the array.
  always_comb begin
    idle_s       = (state_r == ST_IDLE);
    req_s        = mem_read | mem_write;
    misaligned_s = (addr[1:0] != 2'b00);
    oob_s        = ((addr >> (2 + IDX_W)) != 32'd0);
    both_s       = mem_read & mem_write;
    accept_s     = idle_s & req_s & ~(misaligned_s | oob_s | both_s);
    stall        = accept_s | (state_r == ST_WAIT);

    if (idle_s) begin
      // With no wait states the commit edge is the accept edge, so the live
      // request is used before it has been latched.
      commit_s    = accept_s & NO_WAIT;
      acc_idx_s   = addr[2 +: IDX_W];
      acc_wdata_s = wdata;
      acc_write_s = mem_write;
    end else begin
      commit_s    = (state_r == ST_WAIT) & (cnt_r <= CNT_ONE);
      acc_idx_s   = idx_r;
      acc_wdata_s = wdata_r;
      acc_write_s = is_write_r;
    end
  end

  // Control FSM, wait counter, request latch and registered pulse outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      idx_r       <= {IDX_W{1'b0}};
      wdata_r     <= {DATA_W{1'b0}};
      is_write_r  <= 1'b0;
      done_r      <= 1'b0;
      misalign_r  <= 1'b0;
      range_err_r <= 1'b0;
    end else begin
      done_r      <= commit_s;
      misalign_r  <= idle_s & req_s & misaligned_s;
      range_err_r <= idle_s & req_s & ~misaligned_s & (oob_s | both_s);
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            idx_r      <= addr[2 +: IDX_W];
            wdata_r    <= wdata;
            is_write_r <= mem_write;
            cnt_r      <= WAIT_INIT;
            state_r    <= NO_WAIT ? ST_DONE : ST_WAIT;
          end else begin
            state_r    <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          cnt_r <= (cnt_r == {CNT_W{1'b0}}) ? cnt_r : cnt_r - CNT_ONE;
          if (cnt_r <= CNT_ONE) begin
            state_r <= ST_DONE;
          end else begin
            state_r <= ST_WAIT;
          end
        end
        ST_DONE: begin
          // Requests still high here belong to the instruction just completed.
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  dmem_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (commit_s & acc_write_s),
    .re    (commit_s & ~acc_write_s),
    .idx   (acc_idx_s),
    .wdata (acc_wdata_s),
    .rdata (rdata)
  );

  assign done      = done_r;
  assign misalign  = misalign_r;
  assign range_err = range_err_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed, table-driven bench for dmem_responder (WAIT_CYCLES=2 instance)
// plus hand-written sequences and a WAIT_CYCLES=0 instance.
module tb_dmem_responder;

  typedef struct {
    logic        mr;
    logic        mw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        done;
    logic        mis;
    logic        rerr;
    logic [31:0] rdata;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [31:0] addr = 32'h0, wdata = 32'h0;
  logic [31:0] rdata;
  logic        stall, done, misalign, range_err;

  logic        mem_read0 = 1'b0, mem_write0 = 1'b0;
  logic [31:0] addr0 = 32'h0, wdata0 = 32'h0;
  logic [31:0] rdata0;
  logic        stall0, done0, misalign0, range_err0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DATA_W(32), .DEPTH(256), .WAIT_CYCLES(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall), .done(done),
    .misalign(misalign), .range_err(range_err)
  );

  dmem_responder #(.DATA_W(32), .DEPTH(256), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read0), .mem_write(mem_write0),
    .addr(addr0), .wdata(wdata0), .rdata(rdata0), .stall(stall0), .done(done0),
    .misalign(misalign0), .range_err(range_err0)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // One cycle on the WAIT_CYCLES=2 instance: drive at negedge, settle 1 time unit.
  task automatic cyc(input logic mr, input logic mw, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    mem_read = mr; mem_write = mw; addr = a; wdata = d;
    #1;
  endtask

  task automatic cyc0(input logic mr, input logic mw, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    mem_read0 = mr; mem_write0 = mw; addr0 = a; wdata0 = d;
    #1;
  endtask

  // Full access on the WAIT_CYCLES=2 instance with the request held through DONE.
  task automatic access(input logic mr, input logic mw, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output int n_stall, output int n_done);
    rd = 32'hx; n_stall = 0; n_done = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(mr, mw, a, d);
      if (stall === 1'b1) n_stall++;
      if (done === 1'b1) begin
        n_done++;
        rd = rdata;
      end
    end
  endtask

  vec_t vq[$];

  initial begin
    logic [31:0] rd;
    int          ns, nd, tot_s, tot_d;
    logic [31:0] b2b_addr [3];
    logic [31:0] b2b_exp  [3];

    // {mr, mw, addr, wdata | stall, done, misalign, range_err, rdata}
    vq.push_back('{1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0});
    vq.push_back('{1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0});
    vq.push_back('{1'b0, 1'b1, 32'h14,  32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0});
    vq.push_back('{1'b0, 1'b1, 32'h14,  32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0});
    vq.push_back('{1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0});
    vq.push_back('{1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0});
    vq.push_back('{1'b1, 1'b0, 32'h10,  32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'h0});
    vq.push_back('{1'b1, 1'b0, 32'h14,  32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'h0});
    vq.push_back('{1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'h0});
    vq.push_back('{1'b1, 1'b0, 32'h10,  32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF});
    vq.push_back('{1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF});
    vq.push_back('{1'b0, 1'b1, 32'h13,  32'hCAFEF00D, 1'b0, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF});
    vq.push_back('{1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF});
    vq.push_back('{1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF});
    vq.push_back('{1'b1, 1'b0, 32'h10,  32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF});
    vq.push_back('{1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF});
    vq.push_back('{1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF});
    vq.push_back('{1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF});
    vq.push_back('{1'b1, 1'b0, 32'h400, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF});
    vq.push_back('{1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF});
    vq.push_back('{1'b1, 1'b1, 32'h20,  32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF});
    vq.push_back('{1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF});
    vq.push_back('{1'b1, 1'b1, 32'h21,  32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF});
    vq.push_back('{1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF});
    vq.push_back('{1'b0, 1'b1, 32'h3FC, 32'h5A5A0001, 1'b1, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF});
    vq.push_back('{1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF});
    vq.push_back('{1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF});
    vq.push_back('{1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF});
    vq.push_back('{1'b1, 1'b0, 32'h3FC, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF});
    vq.push_back('{1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF});
    vq.push_back('{1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF});
    vq.push_back('{1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 32'h5A5A0001});
    vq.push_back('{1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h5A5A0001});

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vq[i]) begin
      cyc(vq[i].mr, vq[i].mw, vq[i].addr, vq[i].wdata);
      chk($sformatf("row%0d stall", i),     {31'b0, stall},     {31'b0, vq[i].stall});
      chk($sformatf("row%0d done", i),      {31'b0, done},      {31'b0, vq[i].done});
      chk($sformatf("row%0d misalign", i),  {31'b0, misalign},  {31'b0, vq[i].mis});
      chk($sformatf("row%0d range_err", i), {31'b0, range_err}, {31'b0, vq[i].rerr});
      chk($sformatf("row%0d rdata", i),     rdata,              vq[i].rdata);
    end

    // Reset in the second WAIT cycle of a store must abort the write.
    access(1'b0, 1'b1, 32'h20, 32'h11112222, rd, ns, nd);
    cyc(1'b0, 1'b0, 32'h0, 32'h0);
    access(1'b0, 1'b1, 32'h44, 32'h0BADF00D, rd, ns, nd);
    cyc(1'b0, 1'b0, 32'h0, 32'h0);
    cyc(1'b0, 1'b1, 32'h20, 32'hAAAA5555);
    cyc(1'b0, 1'b1, 32'h20, 32'hAAAA5555);
    @(negedge clk);
    rst_n = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0; addr = 32'h0; wdata = 32'h0;
    #1;
    chk("rst stall",     {31'b0, stall},     32'h0);
    chk("rst done",      {31'b0, done},      32'h0);
    chk("rst misalign",  {31'b0, misalign},  32'h0);
    chk("rst range_err", {31'b0, range_err}, 32'h0);
    chk("rst rdata",     rdata,              32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    access(1'b1, 1'b0, 32'h20, 32'h0, rd, ns, nd);
    cyc(1'b0, 1'b0, 32'h0, 32'h0);
    chk("post-rst read 0x20", rd, 32'h11112222);
    chk("post-rst stall cycles", ns, 3);
    chk("post-rst done pulses", nd, 1);

    // Three back-to-back loads with mem_read held continuously.
    b2b_addr[0] = 32'h10;  b2b_exp[0] = 32'hDEADBEEF;
    b2b_addr[1] = 32'h44;  b2b_exp[1] = 32'h0BADF00D;
    b2b_addr[2] = 32'h3FC; b2b_exp[2] = 32'h5A5A0001;
    tot_s = 0; tot_d = 0;
    for (int k = 0; k < 3; k++) begin
      access(1'b1, 1'b0, b2b_addr[k], 32'h0, rd, ns, nd);
      tot_s += ns; tot_d += nd;
      chk($sformatf("b2b%0d rdata", k), rd, b2b_exp[k]);
    end
    cyc(1'b0, 1'b0, 32'h0, 32'h0);
    if (done === 1'b1) tot_d++;
    cyc(1'b0, 1'b0, 32'h0, 32'h0);
    if (done === 1'b1) tot_d++;
    chk("b2b done pulses", tot_d, 3);
    chk("b2b stall cycles", tot_s, 9);

    // WAIT_CYCLES=0 instance: store 0x1234 at word 0, then load it back.
    cyc0(1'b0, 1'b1, 32'h0, 32'h00001234);
    chk("w0 st stall", {31'b0, stall0}, 32'h1);
    chk("w0 st done",  {31'b0, done0},  32'h0);
    cyc0(1'b0, 1'b1, 32'h0, 32'h00001234);
    chk("w0 st done cycle stall", {31'b0, stall0}, 32'h0);
    chk("w0 st done cycle done",  {31'b0, done0},  32'h1);
    cyc0(1'b0, 1'b0, 32'h0, 32'h0);
    chk("w0 idle done", {31'b0, done0}, 32'h0);
    cyc0(1'b1, 1'b0, 32'h0, 32'h0);
    chk("w0 ld stall", {31'b0, stall0}, 32'h1);
    cyc0(1'b1, 1'b0, 32'h0, 32'h0);
    chk("w0 ld done cycle stall", {31'b0, stall0}, 32'h0);
    chk("w0 ld done",  {31'b0, done0},  32'h1);
    chk("w0 ld rdata", rdata0, 32'h00001234);
    cyc0(1'b0, 1'b0, 32'h0, 32'h0);
    chk("w0 after done", {31'b0, done0}, 32'h0);
    chk("w0 rdata held", rdata0, 32'h00001234);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
